carregador_hd: RTL and testbench

Program loader between the hard-disk model and the instruction memory: on a start pulse it rewinds the disk's sequential word pointer, streams a requested number of 32-bit words from a chosen disk sector and writes them into instruction memory at a destination address. It drives the disk's control inputs and consumes its combinational `saida_instr`. It sits beside the process scheduler, which requests program loads before dispatch.

---
 rtl/carregador_hd.sv | 119 +++++++++++
 tb/tb_carregador_hd.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/carregador_hd.sv
// rtl/carregador_hd.sv - program loader: streams disk sector words into instruction memory
// Optional feature macro: CARREGADOR_HALT_EN (stop the copy early after a halt-opcode word)
module carregador_hd #(
    parameter int DADO_W      = 32,
    parameter int SETOR_W     = 10,
    parameter int END_W       = 16,
    parameter int QTD_W       = 9,
    parameter int PRIMEIRO_HD = 32,
    parameter int ULTIMO_HD   = 299
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inicio,
    input  logic [SETOR_W-1:0] setor,
    input  logic [QTD_W-1:0]   qtd_palavras,
    input  logic [END_W-1:0]   end_destino,
    input  logic [DADO_W-1:0]  saida_instr,
    output logic [SETOR_W-1:0] setor_hd,
    output logic [15:0]        endereco_hd,
    output logic [1:0]         controle_hd,
    output logic               mem_we,
    output logic [END_W-1:0]   mem_end,
    output logic [DADO_W-1:0]  mem_dado,
    output logic               ocupado,
    output logic               pronto,
    output logic               erro
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_COPY,
        S_DONE,
        S_FAIL
    } estado_t;

    estado_t              estado_q, estado_d;
    logic [SETOR_W-1:0]   setor_q, setor_d;
    logic [QTD_W-1:0]     cnt_q, cnt_d;
    logic [15:0]          k_q, k_d;
    logic [END_W-1:0]     mem_end_q, mem_end_d;

    // Index of the last word the request would read; must stay inside the sector.
    logic [31:0]          ultimo_pedido;
    logic                 pedido_ok;
    logic                 halt;

    assign ultimo_pedido = 32'(PRIMEIRO_HD) + 32'(qtd_palavras) - 32'd1;
    assign pedido_ok     = (qtd_palavras != '0) && (ultimo_pedido <= 32'(ULTIMO_HD));

`ifdef CARREGADOR_HALT_EN
    assign halt = (saida_instr[DADO_W-1 -: 5] == 5'b11111);
`else
    assign halt = 1'b0;
`endif

    // State and transfer bookkeeping registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q  <= S_IDLE;
            setor_q   <= '0;
            cnt_q     <= '0;
            k_q       <= '0;
            mem_end_q <= '0;
        end else begin
            estado_q  <= estado_d;
            setor_q   <= setor_d;
            cnt_q     <= cnt_d;
            k_q       <= k_d;
            mem_end_q <= mem_end_d;
        end
    end

    // Next-state: latch the request in IDLE, then prime the disk and copy one word per cycle.
    always_comb begin
        estado_d  = estado_q;
        setor_d   = setor_q;
        cnt_d     = cnt_q;
        k_d       = k_q;
        mem_end_d = mem_end_q;
        case (estado_q)
            S_IDLE: begin
                if (inicio) begin
                    setor_d   = setor;
                    cnt_d     = qtd_palavras;
                    mem_end_d = end_destino;
                    k_d       = '0;
                    estado_d  = pedido_ok ? S_PRIME : S_FAIL;
                end
            end
            S_PRIME: estado_d = S_COPY;
            S_COPY: begin
                mem_end_d = mem_end_q + END_W'(1);
                k_d       = k_q + 16'd1;
                cnt_d     = cnt_q - QTD_W'(1);
                if (cnt_q == QTD_W'(1) || halt) begin
                    estado_d = S_DONE;
                end
            end
            S_DONE:  estado_d = S_IDLE;
            S_FAIL:  estado_d = S_IDLE;
            default: estado_d = S_IDLE;
        endcase
    end

    // Outputs decode straight from flops; only the write data passes the disk word through.
    always_comb begin
        controle_hd = ((estado_q == S_PRIME) || (estado_q == S_COPY)) ? 2'b00 : 2'b01;
        mem_we      = (estado_q == S_COPY);
        mem_dado    = (estado_q == S_COPY) ? saida_instr : '0;
        ocupado     = (estado_q == S_PRIME) || (estado_q == S_COPY);
        pronto      = (estado_q == S_DONE);
        erro        = (estado_q == S_FAIL);
        endereco_hd = (estado_q == S_COPY) ? (16'(PRIMEIRO_HD) + k_q) : 16'(PRIMEIRO_HD - 1);
        mem_end     = mem_end_q;
        setor_hd    = setor_q;
    end

endmodule

// File: tb/tb_carregador_hd.sv
// tb/tb_carregador_hd.sv - scoreboard bench for carregador_hd with a sequential disk model
module tb_carregador_hd;

    localparam int PRIMEIRO = 32;
    localparam int ULTIMO   = 299;

    logic        clk = 1'b0;
    logic        reset;
    logic        inicio;
    logic [9:0]  setor;
    logic [8:0]  qtd_palavras;
    logic [15:0] end_destino;
    logic [31:0] saida_instr;
    logic [9:0]  setor_hd;
    logic [15:0] endereco_hd;
    logic [1:0]  controle_hd;
    logic        mem_we;
    logic [15:0] mem_end;
    logic [31:0] mem_dado;
    logic        ocupado;
    logic        pronto;
    logic        erro;

    carregador_hd dut (
        .clk          (clk),
        .reset        (reset),
        .inicio       (inicio),
        .setor        (setor),
        .qtd_palavras (qtd_palavras),
        .end_destino  (end_destino),
        .saida_instr  (saida_instr),
        .setor_hd     (setor_hd),
        .endereco_hd  (endereco_hd),
        .controle_hd  (controle_hd),
        .mem_we       (mem_we),
        .mem_end      (mem_end),
        .mem_dado     (mem_dado),
        .ocupado      (ocupado),
        .pronto       (pronto),
        .erro         (erro)
    );

    always #5 clk = ~clk;

    // Disk contents: a few fixed words in sector 2, a halt word in sectors 2 and 5, hash elsewhere.
    function automatic logic [31:0] disk_word(input logic [9:0] s, input int i);
        logic [31:0] h;
        h = (32'(s) * 32'h9E3779B1) ^ (32'(i) * 32'h85EBCA6B);
        h = {1'b0, h[30:0]};
        if (s == 10'd2 && i == 32)       h = 32'hAFC00009;
        else if (s == 10'd2 && i == 33)  h = 32'h77C00009;
        else if (s == 10'd2 && i == 34)  h = 32'hAFC00006;
        else if (s == 10'd2 && i == 35)  h = 32'h77C0000A;
        else if (s == 10'd2 && i == 123) h = 32'hF8000000;
        else if (s == 10'd5 && i == 40)  h = 32'hF8001234;
        return h;
    endfunction

    // Sequential disk pointer: rewinds on 01, advances on 00.
    int ptr = PRIMEIRO - 1;
    always @(posedge clk) begin
        if (controle_hd == 2'b01) ptr <= PRIMEIRO - 1;
        else if (controle_hd == 2'b00) ptr <= ptr + 1;
    end
    assign saida_instr = disk_word(setor_hd, ptr);

    typedef struct {
        int          kind;   // 0 write, 1 pronto, 2 erro
        logic [31:0] a;
        logic [31:0] d;
        int          ex;     // disk index for writes, ocupado cycles for pronto/erro
    } ev_t;

    ev_t sb[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  ocup_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic pop_check(input int kind, output ev_t e, output bit ok);
        vectors++;
        ok = 1'b0;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event: got kind %0d, expected none", kind);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind) begin
                miscompares++;
                $display("FAIL event_kind: got %0d, expected %0d", kind, e.kind);
            end else ok = 1'b1;
        end
    endtask

    // Monitor: consumes expected events whenever the DUT shows a write or a completion pulse.
    always @(negedge clk) begin
        ev_t e;
        bit  ok;
        if (reset) ocup_cnt = 0;
        else if (ocupado) ocup_cnt++;
        if (mem_we) begin
            pop_check(0, e, ok);
            if (ok) begin
                check("mem_end", 32'(mem_end), e.a);
                check("mem_dado", mem_dado, e.d);
                check("endereco_hd", 32'(endereco_hd), 32'(e.ex));
            end
        end
        if (pronto) begin
            pop_check(1, e, ok);
            if (ok) check("ocupado_cycles", 32'(ocup_cnt), 32'(e.ex));
            ocup_cnt = 0;
        end
        if (erro) begin
            pop_check(2, e, ok);
            if (ok) check("ocupado_on_reject", 32'(ocup_cnt), 32'(e.ex));
            ocup_cnt = 0;
        end
    end

    // Reference model: what a request should produce, from the loader's rules.
    task automatic queue_req(input logic [9:0] s, input int q, input logic [15:0] dst);
        ev_t e;
        int  n = 0;
        if (q == 0 || PRIMEIRO + q - 1 > ULTIMO) begin
            e.kind = 2; e.a = 0; e.d = 0; e.ex = 0;
            sb.push_back(e);
        end else begin
            for (int i = 0; i < q; i++) begin
                e.kind = 0;
                e.d    = disk_word(s, PRIMEIRO + i);
                e.a    = 32'(16'(dst + 16'(i)));
                e.ex   = PRIMEIRO + i;
                sb.push_back(e);
                n++;
`ifdef CARREGADOR_HALT_EN
                if (e.d[31:27] == 5'b11111) break;
`endif
            end
            e.kind = 1; e.a = 0; e.d = 0; e.ex = n + 1;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done();
        int t = 0;
        while ((sb.size() != 0 || ocupado || pronto || erro) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (t >= 3000) begin
            miscompares++;
            $display("FAIL timeout: got %0d pending events, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_req(input logic [9:0] s, input int q, input logic [15:0] dst);
        @(negedge clk);
        setor        = s;
        qtd_palavras = 9'(q);
        end_destino  = dst;
        inicio       = 1'b1;
        queue_req(s, q, dst);
        @(negedge clk);
        inicio = 1'b0;
        wait_done();
    endtask

    initial begin
        reset = 1'b1;
        inicio = 1'b0;
        setor = '0;
        qtd_palavras = '0;
        end_destino = '0;
        repeat (3) @(negedge clk);
        check("rst_controle_hd", 32'(controle_hd), 32'd1);
        check("rst_setor_hd", 32'(setor_hd), 32'd0);
        check("rst_endereco_hd", 32'(endereco_hd), 32'(PRIMEIRO - 1));
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_end", 32'(mem_end), 32'd0);
        check("rst_mem_dado", mem_dado, 32'd0);
        check("rst_ocupado", 32'(ocupado), 32'd0);
        check("rst_pronto", 32'(pronto), 32'd0);
        check("rst_erro", 32'(erro), 32'd0);
        reset = 1'b0;

        run_req(10'd2, 4, 16'h0010);
        check("setor_hd_latched", 32'(setor_hd), 32'd2);
        run_req(10'd2, 0, 16'h0000);
        run_req(10'd2, 269, 16'h0000);
        run_req(10'd2, 268, 16'h0100);
        run_req(10'd2, 100, 16'h0000);
        run_req(10'd2, 2, 16'hFFFF);

        // inicio held high: one transfer, then a second only after IDLE is re-entered.
        @(negedge clk);
        setor = 10'd2; qtd_palavras = 9'd3; end_destino = 16'h0200; inicio = 1'b1;
        queue_req(10'd2, 3, 16'h0200);
        queue_req(10'd2, 3, 16'h0200);
        repeat (7) @(negedge clk);
        inicio = 1'b0;
        wait_done();

        // Reset during the second COPY cycle: two writes land, then the loader is idle.
        @(negedge clk);
        setor = 10'd2; qtd_palavras = 9'd5; end_destino = 16'h0040; inicio = 1'b1;
        queue_req(10'd2, 2, 16'h0040);
        void'(sb.pop_back());
        @(negedge clk);
        inicio = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_mem_we", 32'(mem_we), 32'd0);
        check("midrst_controle_hd", 32'(controle_hd), 32'd1);
        check("midrst_ocupado", 32'(ocupado), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check("midrst_pending", 32'(sb.size()), 32'd0);
        run_req(10'd2, 2, 16'h0080);

        for (int it = 0; it < 24; it++) begin
            int r;
            int q;
            r = $urandom_range(0, 9);
            if (r == 0)      q = 0;
            else if (r == 1) q = $urandom_range(269, 511);
            else if (r == 2) q = 268;
            else             q = $urandom_range(1, 40);
            run_req(10'($urandom_range(0, 7)), q, 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
